hazard_sequencer: RTL and testbench
===================================

Name: hazard_sequencer

Overview:
- Pipeline hazard sequencer for the 5-stage MIPS datapath.
- Detects load-use and jr register hazards in ID, sequences multi-cycle stalls, and issues IF/ID and ID/EX flushes for jumps (ID) and taken branches (EX).
- Drives the PC/IF-ID write enables and ID/EX bubble insertion.
- Drives the Controller's 3-bit hazardjump input: 0 = none, 1 = jump flush, 2 = stall.

Parameters:
- REG_ADDR_W, 5, register-specifier width.
- CNT_W, 16, width of the perf counters.
- JR_MAX_WAIT, 2, watchdog limit on consecutive JR_WAIT cycles.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- id_rs  in  REG_ADDR_W  rs field of the instruction in ID.
- id_rt  in  REG_ADDR_W  rt field of the instruction in ID.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt.
- id_jump  in  1  j or jal in ID (JumpInstCont==1).
- id_jr  in  1  jr in ID (JumpInstCont==2).
- ex_mem_read  in  1  EX-stage instruction is a load.
- ex_reg_write  in  1  EX-stage instruction writes a register.
- ex_rd  in  REG_ADDR_W  EX-stage destination register.
- mem_mem_read  in  1  MEM-stage instruction is a load.
- mem_reg_write  in  1  MEM-stage instruction writes a register.
- mem_rd  in  REG_ADDR_W  MEM-stage destination register.
- ex_branch_taken  in  1  branch resolved taken in EX.
- pc_write  out  1  PC update enable.
- ifid_write  out  1  IF/ID register enable.
- ifid_flush  out  1  clear IF/ID to nop.
- idex_bubble  out  1  zero the ID/EX control fields.
- hazardjump  out  3  code to the Controller.
- seq_state  out  2  current FSM state: 0 RUN, 1 LOAD_STALL, 2 JR_WAIT, 3 ERR.
- wd_err  out  1  sticky watchdog error flag.

Behaviour:
- Outputs are Mealy (combinational from state + inputs). The state register, wait counter and wd_err are clocked on posedge clk and cleared asynchronously when rst_n=0.
- While rst_n=0: pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1, hazardjump=0, seq_state=RUN, wd_err=0.
- Register $0 never causes a hazard: any rd==0 match is ignored.
- load_use = ex_mem_read & (ex_rd!=0) & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)).
- jr_dep = id_jr & (id_rs!=0) & ((ex_reg_write & id_rs==ex_rd) | (mem_reg_write & id_rs==mem_rd)). jr reads the register file in ID with no forwarding.
- Priority, highest first: ex_branch_taken > jr_dep > load_use > id_jump.
- Branch taken (any state): ifid_flush=1, idex_bubble=1, pc_write=1, hazardjump=0. Next state RUN, wait counter cleared.
- jr_dep: pc_write=0, ifid_write=0, idex_bubble=1, hazardjump=2. Next state JR_WAIT, counter incremented.
- load_use: pc_write=0, ifid_write=0, idex_bubble=1, hazardjump=2. Next state LOAD_STALL. Exactly 1 stall cycle results.
- id_jump (no higher-priority event): ifid_flush=1, hazardjump=1, pc_write=1. State stays RUN.
- No event: pc_write=1, ifid_write=1, all flushes 0, hazardjump=0.
- LOAD_STALL: re-evaluate the priority list. With no event, return to RUN. A second load_use in this state is legal (back-to-back loads) and stays in LOAD_STALL.
- JR_WAIT: stay while jr_dep holds, incrementing the counter. When jr_dep clears, return to RUN and clear the counter. The jr then proceeds with hazardjump=1 to flush the wrong-path fetch.
- Watchdog: if the counter exceeds JR_MAX_WAIT, go to ERR and set wd_err (sticky until reset). In ERR: pc_write=0, ifid_write=0, idex_bubble=1. Only rst_n exits ERR.
- Reset asserted mid-stall: immediate return to RUN with reset outputs. No stall state survives reset.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined: adds outputs stall_cnt[CNT_W] and flush_cnt[CNT_W].
  - stall_cnt increments on each cycle with hazardjump==2.
  - flush_cnt increments on each cycle with ifid_flush=1 outside reset.
  - Both saturate at all-ones and are cleared by rst_n.
- Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- Shared package hazard_pkg:
  - FSM state encoding: RUN/LOAD_STALL/JR_WAIT/ERR.
  - hazardjump codes: HJ_NONE=0, HJ_FLUSH=1, HJ_STALL=2.
  - REG_ZERO constant.
- Sub-module hazard_match: purely combinational. Computes load_use and jr_dep from the register fields. Reused by a future forwarding unit.
- FSM, watchdog and perf counters stay in hazard_sequencer.

Test Plan:
- lw $t0 in EX (ex_mem_read=1, ex_rd=8), add in ID with id_rs=8, id_uses_rs=1 -> one cycle of pc_write=0, idex_bubble=1, hazardjump=2, seq_state=1; next cycle RUN, pc_write=1.
- Same as above with ex_rd=0 -> no stall, hazardjump=0.
- jr $ra (id_rs=31): ex_reg_write=1, ex_rd=31, then mem_reg_write=1, mem_rd=31 -> 2 stall cycles in JR_WAIT; 3rd cycle hazardjump=1, ifid_flush=1, wd_err=0.
- jr dependency held for 3 cycles with JR_MAX_WAIT=2 -> seq_state=3, wd_err=1, pc_write stuck 0 until rst_n pulse.
- ex_branch_taken=1 in the same cycle as load_use -> ifid_flush=1, idex_bubble=1, pc_write=1, hazardjump=0, next state RUN.
- With HAZARD_PERF_CNT_EN, CNT_W=4: 20 consecutive stall cycles -> stall_cnt saturates at 15; rst_n low -> stall_cnt=0 and flush_cnt=0 asynchronously.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared FSM state encoding, Controller hazardjump codes and register-zero constant
package hazard_pkg;
    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        JR_WAIT    = 2'd2,
        ERR        = 2'd3
    } seq_state_e;
    localparam logic [2:0] HJ_NONE  = 3'd0;
    localparam logic [2:0] HJ_FLUSH = 3'd1;
    localparam logic [2:0] HJ_STALL = 3'd2;
    localparam int REG_ZERO = 0;
endpackage

// File: rtl/hazard_match.sv
// hazard_match: combinational load-use and jr register dependency detection
// Ports: ID rs/rt fields and use flags, id_jr, EX load/write/rd, MEM write/rd -> load_use, jr_dep.
module hazard_match
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic                  id_jr,
    input  logic                  ex_mem_read,
    input  logic                  ex_reg_write,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  mem_reg_write,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    output logic                  load_use,
    output logic                  jr_dep
);
    localparam logic [REG_ADDR_W-1:0] ZERO = REG_ADDR_W'(REG_ZERO);
    assign load_use = ex_mem_read & (ex_rd != ZERO) &
                      ((id_uses_rs & (id_rs == ex_rd)) | (id_uses_rt & (id_rt == ex_rd)));
    // jr reads the register file in ID with no forwarding, so any in-flight writer of rs blocks it
    assign jr_dep = id_jr & (id_rs != ZERO) &
                    ((ex_reg_write & (id_rs == ex_rd)) | (mem_reg_write & (id_rs == mem_rd)));
endmodule

// File: rtl/hazard_sequencer.sv
// hazard_sequencer: MIPS 5-stage hazard FSM driving stalls, flushes and the Controller hazardjump code
// Ports: ID/EX/MEM hazard sources and ex_branch_taken in; pc_write, ifid_write, ifid_flush,
// idex_bubble, hazardjump, seq_state, wd_err out. Optional HAZARD_PERF_CNT_EN adds stall_cnt/flush_cnt.
module hazard_sequencer
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W  = 5,
    parameter int CNT_W       = 16,
    parameter int JR_MAX_WAIT = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic                  id_jump,
    input  logic                  id_jr,
    input  logic                  ex_mem_read,
    input  logic                  ex_reg_write,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  mem_mem_read,
    input  logic                  mem_reg_write,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  ex_branch_taken,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  ifid_flush,
    output logic                  idex_bubble,
    output logic [2:0]            hazardjump,
    output logic [1:0]            seq_state,
`ifdef HAZARD_PERF_CNT_EN
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt,
`endif
    output logic                  wd_err
);
    // counter must be able to hold JR_MAX_WAIT+1, the value that trips the watchdog
    localparam int WAIT_W = $clog2(JR_MAX_WAIT + 2);

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be positive");
    end

    seq_state_e        state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d, wait_inc;
    logic              wd_err_q;
    logic              load_use, jr_dep;
    logic              pc_w, ifid_w, flush, bubble;
    logic [2:0]        hj;
    // a load in MEM is already forwardable, so only its write/rd matter for jr
    logic              unused_mem_mem_read;

    assign unused_mem_mem_read = mem_mem_read;

    hazard_match #(.REG_ADDR_W(REG_ADDR_W)) u_match (
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rs   (id_uses_rs),
        .id_uses_rt   (id_uses_rt),
        .id_jr        (id_jr),
        .ex_mem_read  (ex_mem_read),
        .ex_reg_write (ex_reg_write),
        .ex_rd        (ex_rd),
        .mem_reg_write(mem_reg_write),
        .mem_rd       (mem_rd),
        .load_use     (load_use),
        .jr_dep       (jr_dep)
    );

    assign wait_inc = wait_q + WAIT_W'(1);

    always_comb begin
        state_d = RUN;
        wait_d  = '0;
        pc_w    = 1'b1;
        ifid_w  = 1'b1;
        flush   = 1'b0;
        bubble  = 1'b0;
        hj      = HJ_NONE;
        if (state_q == ERR) begin
            pc_w    = 1'b0;
            ifid_w  = 1'b0;
            bubble  = 1'b1;
            hj      = HJ_STALL;
            state_d = ERR;
            wait_d  = wait_q;
        end else if (ex_branch_taken) begin
            flush  = 1'b1;
            bubble = 1'b1;
        end else if (jr_dep) begin
            pc_w    = 1'b0;
            ifid_w  = 1'b0;
            bubble  = 1'b1;
            hj      = HJ_STALL;
            wait_d  = wait_inc;
            state_d = (wait_inc > WAIT_W'(JR_MAX_WAIT)) ? ERR : JR_WAIT;
        end else if (load_use) begin
            pc_w    = 1'b0;
            ifid_w  = 1'b0;
            bubble  = 1'b1;
            hj      = HJ_STALL;
            state_d = LOAD_STALL;
        end else if (id_jump || state_q == JR_WAIT) begin
            // a released jr behaves like a jump: flush the wrong-path fetch
            flush = 1'b1;
            hj    = HJ_FLUSH;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            wait_q   <= '0;
            wd_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            wd_err_q <= wd_err_q | (state_d == ERR);
        end
    end

    // reset forces a safe pipeline: frozen fetch, nop in IF/ID and ID/EX
    assign pc_write    = rst_n & pc_w;
    assign ifid_write  = rst_n & ifid_w;
    assign ifid_flush  = ~rst_n | flush;
    assign idex_bubble = ~rst_n | bubble;
    assign hazardjump  = rst_n ? hj : HJ_NONE;
    assign seq_state   = state_q;
    assign wd_err      = wd_err_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (hj == HJ_STALL && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (flush && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif
endmodule

// File: tb/tb_hazard_sequencer.sv
// tb_hazard_sequencer: vector table, hand sequences and random run against a decision-table model
module tb_hazard_sequencer;
    localparam int CW   = 4;
    localparam int MAXW = 2;
    localparam logic [8:0] URS = 9'h100, URT = 9'h080, JMP = 9'h040, JR = 9'h020, EXMR = 9'h010;
    localparam logic [8:0] EXRW = 9'h008, MEMMR = 9'h004, MEMRW = 9'h002, BR = 9'h001;
    localparam int A_RUN = 0, A_JUMP = 1, A_LU = 2, A_JR = 3, A_BR = 4, A_ERR = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [4:0] id_rs, id_rt, ex_rd, mem_rd;
    logic       id_uses_rs, id_uses_rt, id_jump, id_jr, ex_mem_read, ex_reg_write;
    logic       mem_mem_read, mem_reg_write, ex_branch_taken;
    logic       pc_write, ifid_write, ifid_flush, idex_bubble, wd_err;
    logic [2:0] hazardjump;
    logic [1:0] seq_state;
`ifdef HAZARD_PERF_CNT_EN
    logic [CW-1:0] stall_cnt, flush_cnt;
`endif

    hazard_sequencer #(.REG_ADDR_W(5), .CNT_W(CW), .JR_MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_jump(id_jump), .id_jr(id_jr),
        .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .ex_rd(ex_rd),
        .mem_mem_read(mem_mem_read), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
        .ex_branch_taken(ex_branch_taken),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .hazardjump(hazardjump), .seq_state(seq_state),
`ifdef HAZARD_PERF_CNT_EN
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
        .wd_err(wd_err)
    );

    typedef struct {
        logic [4:0] rs, rt, exrd, memrd;
        logic [8:0] f;
        logic [3:0] o;
        logic [2:0] hj;
        logic [1:0] ns;
    } vec_t;

    vec_t tbl [16];
    int   checks = 0, failures = 0;
    int   m_st, m_w, m_sc, m_fc, a;
    bit   m_err, lu, jd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rs, rt, exrd, memrd, input logic [8:0] f);
        id_rs = rs; id_rt = rt; ex_rd = exrd; mem_rd = memrd;
        {id_uses_rs, id_uses_rt, id_jump, id_jr, ex_mem_read, ex_reg_write,
         mem_mem_read, mem_reg_write, ex_branch_taken} = f;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
    endtask

    function automatic logic [3:0] outs();
        return {pc_write, ifid_write, ifid_flush, idex_bubble};
    endfunction

    // decision table: which rule of the priority list governs this cycle
    function automatic int decide(int st, bit l, bit j, bit jmp, bit br);
        if (st == 3) return A_ERR;
        if (br) return A_BR;
        if (j) return A_JR;
        if (l) return A_LU;
        if (jmp || st == 2) return A_JUMP;
        return A_RUN;
    endfunction

    function automatic logic [3:0] exp_o(int act);
        case (act)
            A_RUN:   return 4'b1100;
            A_JUMP:  return 4'b1110;
            A_BR:    return 4'b1111;
            default: return 4'b0001;
        endcase
    endfunction

    function automatic logic [2:0] exp_hj(int act);
        return (act == A_JUMP) ? 3'd1 : (act == A_LU || act == A_JR || act == A_ERR) ? 3'd2 : 3'd0;
    endfunction

    function automatic logic [4:0] pick_reg();
        return ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
    endfunction

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        #1;
        chk("reset_outs", outs(), 4'b0011);
        chk("reset_hj", hazardjump, 0);
        chk("reset_state", seq_state, 0);
        chk("reset_wd", wd_err, 0);
        step();
        rst_n = 1'b1;

        tbl[0]  = '{5'd0,  5'd0, 5'd0,  5'd0,  9'h0,                   4'b1100, 3'd0, 2'd0};
        tbl[1]  = '{5'd8,  5'd0, 5'd8,  5'd0,  URS|EXMR|EXRW,          4'b0001, 3'd2, 2'd1};
        tbl[2]  = '{5'd0,  5'd0, 5'd0,  5'd0,  URS|EXMR|EXRW,          4'b1100, 3'd0, 2'd0};
        tbl[3]  = '{5'd1,  5'd9, 5'd9,  5'd0,  URS|URT|EXMR|EXRW,      4'b0001, 3'd2, 2'd1};
        tbl[4]  = '{5'd1,  5'd9, 5'd9,  5'd0,  URS|EXMR|EXRW,          4'b1100, 3'd0, 2'd0};
        tbl[5]  = '{5'd0,  5'd0, 5'd0,  5'd0,  JMP,                    4'b1110, 3'd1, 2'd0};
        tbl[6]  = '{5'd8,  5'd0, 5'd8,  5'd0,  URS|EXMR|EXRW|BR,       4'b1111, 3'd0, 2'd0};
        tbl[7]  = '{5'd31, 5'd0, 5'd31, 5'd0,  URS|JR|EXRW,            4'b0001, 3'd2, 2'd2};
        tbl[8]  = '{5'd31, 5'd0, 5'd0,  5'd31, URS|JR|MEMRW,           4'b0001, 3'd2, 2'd2};
        tbl[9]  = '{5'd0,  5'd0, 5'd0,  5'd0,  URS|JR|EXRW|MEMRW,      4'b1100, 3'd0, 2'd0};
        tbl[10] = '{5'd5,  5'd0, 5'd5,  5'd0,  URS|JR|EXMR|EXRW,       4'b0001, 3'd2, 2'd2};
        tbl[11] = '{5'd8,  5'd0, 5'd8,  5'd0,  URS|EXMR|EXRW|JMP,      4'b0001, 3'd2, 2'd1};
        tbl[12] = '{5'd31, 5'd0, 5'd31, 5'd0,  URS|JR|EXRW|BR,         4'b1111, 3'd0, 2'd0};
        tbl[13] = '{5'd8,  5'd0, 5'd8,  5'd0,  URS|EXRW,               4'b1100, 3'd0, 2'd0};
        tbl[14] = '{5'd7,  5'd0, 5'd0,  5'd7,  URS|MEMMR|MEMRW,        4'b1100, 3'd0, 2'd0};
        tbl[15] = '{5'd31, 5'd0, 5'd30, 5'd0,  URS|JR|EXRW,            4'b1100, 3'd0, 2'd0};

        for (int i = 0; i < 16; i++) begin
            do_reset();
            drive(tbl[i].rs, tbl[i].rt, tbl[i].exrd, tbl[i].memrd, tbl[i].f);
            #1;
            chk($sformatf("vec%0d_outs", i), outs(), tbl[i].o);
            chk($sformatf("vec%0d_hj", i), hazardjump, tbl[i].hj);
            step();
            chk($sformatf("vec%0d_next", i), seq_state, tbl[i].ns);
        end

        // lw $t0 then dependent add: one stall, then run from LOAD_STALL
        do_reset();
        drive(8, 0, 8, 0, URS|EXMR|EXRW);
        #1;
        chk("lu_stall_hj", hazardjump, 2);
        step();
        drive(8, 0, 9, 8, URS|MEMMR|MEMRW);
        #1;
        chk("lu_after_state", seq_state, 1);
        chk("lu_after_outs", outs(), 4'b1100);
        step();
        chk("lu_back_run", seq_state, 0);

        // jr $ra behind writers in EX then MEM: two stalls, then a jump-style flush
        do_reset();
        drive(31, 0, 31, 0, URS|JR|EXRW);
        #1;
        chk("jr_c1_outs", outs(), 4'b0001);
        step();
        drive(31, 0, 3, 31, URS|JR|MEMRW);
        #1;
        chk("jr_c2_state", seq_state, 2);
        chk("jr_c2_hj", hazardjump, 2);
        step();
        drive(31, 0, 3, 4, URS|JR);
        #1;
        chk("jr_c3_hj", hazardjump, 1);
        chk("jr_c3_outs", outs(), 4'b1110);
        chk("jr_c3_wd", wd_err, 0);
        step();
        chk("jr_c3_next", seq_state, 0);

        // dependency held three cycles trips the watchdog; ERR ignores branches
        do_reset();
        drive(31, 0, 31, 0, URS|JR|EXRW);
        repeat (3) step();
        chk("wd_state", seq_state, 3);
        chk("wd_flag", wd_err, 1);
        drive(0, 0, 0, 0, BR);
        #1;
        chk("wd_err_outs", outs(), 4'b0001);
        step();
        step();
        chk("wd_stuck", {seq_state, pc_write}, {2'd3, 1'b0});
        rst_n = 1'b0;
        #1;
        chk("wd_rst_state", {seq_state, wd_err}, {2'd0, 1'b0});
        step();
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0);
        #1;
        chk("wd_after_pc", pc_write, 1);

        // back-to-back loads stay in LOAD_STALL; reset mid-stall returns to RUN at once
        do_reset();
        drive(8, 0, 8, 0, URS|EXMR|EXRW);
        step();
        drive(9, 0, 9, 8, URS|EXMR|EXRW);
        #1;
        chk("b2b_hj", hazardjump, 2);
        step();
        chk("b2b_state", seq_state, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_state", seq_state, 0);
        chk("midrst_outs", {outs(), hazardjump}, {4'b0011, 3'd0});
        step();
        rst_n = 1'b1;

`ifdef HAZARD_PERF_CNT_EN
        do_reset();
        chk("perf_rst_stall", stall_cnt, 0);
        drive(8, 0, 8, 0, URS|EXMR|EXRW);
        repeat (20) step();
        chk("perf_stall_sat", stall_cnt, 15);
        drive(0, 0, 0, 0, JMP);
        repeat (3) step();
        chk("perf_flush", flush_cnt, 3);
        rst_n = 1'b0;
        #1;
        chk("perf_async_clr", {stall_cnt, flush_cnt}, 0);
        step();
        rst_n = 1'b1;
`endif

        do_reset();
        m_st = 0; m_w = 0; m_err = 0; m_sc = 0; m_fc = 0;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 49) == 0) begin
                rst_n = 1'b0;
                #1;
                chk("rnd_rst", {outs(), hazardjump, seq_state, wd_err}, {4'b0011, 3'd0, 2'd0, 1'b0});
                m_st = 0; m_w = 0; m_err = 0; m_sc = 0; m_fc = 0;
                step();
                rst_n = 1'b1;
            end else begin
                id_rs = pick_reg(); id_rt = pick_reg(); ex_rd = pick_reg(); mem_rd = pick_reg();
                id_uses_rs = 1'($urandom_range(0, 1)); id_uses_rt = 1'($urandom_range(0, 1));
                id_jump = ($urandom_range(0, 4) == 0); id_jr = ($urandom_range(0, 2) == 0);
                ex_mem_read = 1'($urandom_range(0, 1)); ex_reg_write = 1'($urandom_range(0, 1));
                mem_mem_read = 1'($urandom_range(0, 1)); mem_reg_write = 1'($urandom_range(0, 1));
                ex_branch_taken = ($urandom_range(0, 7) == 0);
                #1;
                lu = ex_mem_read && ex_rd != 0 &&
                     ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
                jd = id_jr && id_rs != 0 &&
                     ((ex_reg_write && id_rs == ex_rd) || (mem_reg_write && id_rs == mem_rd));
                a = decide(m_st, lu, jd, id_jump, ex_branch_taken);
                chk("rnd_outs", outs(), exp_o(a));
                chk("rnd_hj", hazardjump, exp_hj(a));
                chk("rnd_state", seq_state, m_st);
                chk("rnd_wd", wd_err, m_err);
`ifdef HAZARD_PERF_CNT_EN
                chk("rnd_stall_cnt", stall_cnt, m_sc);
                chk("rnd_flush_cnt", flush_cnt, m_fc);
`endif
                step();
                if (exp_hj(a) == 2 && m_sc < 15) m_sc++;
                if (exp_o(a) == 4'b1110 || exp_o(a) == 4'b1111) m_fc = (m_fc < 15) ? m_fc + 1 : m_fc;
                if (a == A_JR) begin
                    m_w++;
                    m_st = (m_w > MAXW) ? 3 : 2;
                end else if (a != A_ERR) begin
                    m_w = 0;
                    m_st = (a == A_LU) ? 1 : 0;
                end
                if (m_st == 3) m_err = 1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
